tone_generator: RTL and testbench

- Downstream of the keyboard lookup stage in the synthesizer path.
- Takes the 32-bit half-period count for the pressed key and produces a square-wave tone.
- Shapes the tone with a linear attack/sustain/release amplitude envelope.
- Emits one signed audio sample per sample strobe to the audio codec interface.

---
 rtl/tone_generator.sv | 142 ++++++++++++++
 tb/tb_tone_generator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
// Square-wave tone oscillator with a linear attack/sustain/release envelope, one signed sample per sample_tick.
// Optional octave shift of the latched period is enabled by defining TONE_OCTAVE_EN.
module tone_generator #(
   parameter int               AMP_W        = 24,
   parameter logic [AMP_W-1:0] AMP_MAX      = 24'd4194304,
   parameter logic [AMP_W-1:0] ATTACK_STEP  = 24'd4096,
   parameter logic [AMP_W-1:0] RELEASE_STEP = 24'd2048
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [31:0]      half_period,
   input  logic             note_on,
`ifdef TONE_OCTAVE_EN
   input  logic [1:0]       octave_sel,
`endif
   input  logic             sample_tick,
   output logic [AMP_W-1:0] sample,
   output logic             sample_valid,
   output logic [1:0]       env_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } env_state_t;

   env_state_t       state_q, state_d;
   logic [31:0]      counter_q, counter_d;
   logic [31:0]      active_period_q, active_period_d;
   logic             polarity_q, polarity_d;
   logic [AMP_W-1:0] amp_q, amp_d;
   logic [AMP_W-1:0] sample_q, sample_d;
   logic             sample_valid_q, sample_valid_d;

   logic [31:0]      period_src;
   logic [AMP_W:0]   amp_up;
   logic [AMP_W-1:0] amp_sat;
   logic [AMP_W-1:0] amp_rel;

`ifdef TONE_OCTAVE_EN
   logic [31:0] period_shifted;

   // A nonzero request must never collapse to the "no note" value after shifting.
   always_comb begin
      period_shifted = half_period >> octave_sel;
      period_src     = period_shifted;
      if (half_period != '0 && period_shifted == '0) begin
         period_src = 32'd1;
      end
   end
`else
   assign period_src = half_period;
`endif

   // Oscillator: the >= compare also wraps cleanly when the period shrinks below the count.
   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      counter_d       = counter_q;
      polarity_d      = polarity_q;
      active_period_d = active_period_q;
      if (active_period_q == '0) begin
         active_period_d = period_src;
      end else if (counter_q >= active_period_q - 32'd1) begin
         counter_d       = '0;
         polarity_d      = ~polarity_q;
         active_period_d = period_src;
      end else begin
         counter_d = counter_q + 32'd1;
      end
   end

   // Saturating envelope arithmetic; the extra bit on the add prevents wrap-around.
   always_comb begin
      amp_up  = {1'b0, amp_q} + {1'b0, ATTACK_STEP};
      amp_sat = (amp_up >= {1'b0, AMP_MAX}) ? AMP_MAX : amp_up[AMP_W-1:0];
      amp_rel = (amp_q > RELEASE_STEP) ? (amp_q - RELEASE_STEP) : '0;
   end

   always_comb begin
      state_d = state_q;
      if (sample_tick) begin
         unique case (state_q)
            IDLE:    if (note_on) state_d = ATTACK;
            ATTACK:  if (!note_on) state_d = RELEASE;
                     else if (amp_sat == AMP_MAX) state_d = SUSTAIN;
            SUSTAIN: if (!note_on) state_d = RELEASE;
            RELEASE: if (note_on) state_d = ATTACK;
                     else if (amp_rel == '0) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Sample is built from the pre-update amp and pre-toggle polarity.
   always_comb begin
      amp_d          = amp_q;
      sample_d       = sample_q;
      sample_valid_d = sample_tick;
      if (sample_tick) begin
         unique case (state_q)
            IDLE:    amp_d = '0;
            ATTACK:  if (note_on) amp_d = amp_sat;
            SUSTAIN: amp_d = amp_q;
            RELEASE: if (!note_on) amp_d = amp_rel;
            default: amp_d = '0;
         endcase
         if (active_period_q == '0) begin
            sample_d = '0;
         end else begin
            sample_d = polarity_q ? amp_q : (~amp_q + 1'b1);
         end
      end
   end

   always_ff @(posedge clock or posedge resetn) begin
      if (resetn) begin
         state_q         <= IDLE;
         counter_q       <= '0;
         active_period_q <= '0;
         polarity_q      <= 1'b0;
         amp_q           <= '0;
         sample_q        <= '0;
         sample_valid_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         state_q         <= state_d;
         counter_q       <= counter_d;
         active_period_q <= active_period_d;
         polarity_q      <= polarity_d;
         amp_q           <= amp_d;
         sample_q        <= sample_d;
         sample_valid_q  <= sample_valid_d;
      end
   end

   assign sample       = sample_q;
   assign sample_valid = sample_valid_q;
   assign env_state    = state_q;

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: a behavioural model predicts each sample, a monitor compares on sample_valid.
module tb_tone_generator;

   localparam int     AMP_W    = 24;
   localparam longint AMP_MAX  = 4194304;
   localparam longint ATK_STEP = 4096;
   localparam longint REL_STEP = 2048;

   logic             clock       = 1'b0;
   logic             resetn      = 1'b1;
   logic [31:0]      half_period = '0;
   logic             note_on     = 1'b0;
   logic             sample_tick = 1'b0;
`ifdef TONE_OCTAVE_EN
   logic [1:0]       octave_sel  = 2'd0;
`endif
   logic [AMP_W-1:0] sample;
   logic             sample_valid;
   logic [1:0]       env_state;

   tone_generator dut (
      .clock       (clock),
      .resetn      (resetn),
      .half_period (half_period),
      .note_on     (note_on),
`ifdef TONE_OCTAVE_EN
      .octave_sel  (octave_sel),
`endif
      .sample_tick (sample_tick),
      .sample      (sample),
      .sample_valid(sample_valid),
      .env_state   (env_state)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      longint smp;
      longint st;
   } exp_t;

   exp_t   sb_q[$];
   exp_t   mon_e;

   // Reference model state: amplitude and envelope phase as plain integers.
   longint m_period;
   longint m_elapsed;
   bit     m_high;
   longint m_amp;
   int     m_phase; // 0 idle, 1 attack, 2 sustain, 3 release

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint eff_period(input logic [31:0] hp);
`ifdef TONE_OCTAVE_EN
      longint s;
      s = longint'(hp >> octave_sel);
      if (hp != 0 && s == 0) s = 1;
      return s;
`else
      return longint'(hp);
`endif
   endfunction

   function automatic void model_reset();
      m_period  = 0;
      m_elapsed = 0;
      m_high    = 1'b0;
      m_amp     = 0;
      m_phase   = 0;
   endfunction

   // Predicts what the coming rising edge does with the given inputs.
   function automatic void model_clock(input bit on, input logic [31:0] hp, input bit tick);
      exp_t e;
      if (tick) begin
         if (m_period == 0) e.smp = 0;
         else               e.smp = m_high ? m_amp : -m_amp;
         case (m_phase)
            0: begin
               m_amp = 0;
               if (on) m_phase = 1;
            end
            1: begin
               if (!on) m_phase = 3;
               else begin
                  m_amp = (m_amp + ATK_STEP > AMP_MAX) ? AMP_MAX : m_amp + ATK_STEP;
                  if (m_amp == AMP_MAX) m_phase = 2;
               end
            end
            2: if (!on) m_phase = 3;
            default: begin
               if (on) m_phase = 1;
               else begin
                  m_amp = (m_amp - REL_STEP < 0) ? 0 : m_amp - REL_STEP;
                  if (m_amp == 0) m_phase = 0;
               end
            end
         endcase
         e.st = m_phase;
         sb_q.push_back(e);
      end
      // Half-cycle of m_period clocks; a new length is adopted only at the half-cycle boundary.
      if (m_period == 0) begin
         m_period = eff_period(hp);
      end else if (m_elapsed + 1 >= m_period) begin
         m_elapsed = 0;
         m_high    = ~m_high;
         m_period  = eff_period(hp);
      end else begin
         m_elapsed++;
      end
   endfunction

   task automatic step(input bit on, input logic [31:0] hp, input bit tick);
      @(negedge clock);
      note_on     = on;
      half_period = hp;
      sample_tick = tick;
      model_clock(on, hp, tick);
   endtask

   task automatic do_reset(input int hold_cycles);
      @(negedge clock);
      resetn      = 1'b1;
      sample_tick = 1'b0;
      note_on     = 1'b0;
      #1;
      check("rst_sample", longint'(sample), 0);
      check("rst_valid", longint'(sample_valid), 0);
      check("rst_env", longint'(env_state), 0);
      model_reset();
      sb_q.delete();
      repeat (hold_cycles) begin
         @(posedge clock);
         #2;
         check("rst_hold_valid", longint'(sample_valid), 0);
         check("rst_hold_env", longint'(env_state), 0);
      end
      @(negedge clock);
      resetn = 1'b0;
      model_clock(1'b0, half_period, 1'b0);
   endtask

   always @(posedge clock) begin
      #1;
      if (!resetn && (sample_valid || sb_q.size() > 0)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_valid", longint'(sample_valid), 0);
         end else begin
            mon_e = sb_q.pop_front();
            check("sample_valid", longint'(sample_valid), 1);
            check("sample", longint'($signed(sample)), mon_e.smp);
            check("env_state", longint'(env_state), mon_e.st);
         end
      end
   end

   initial begin
      logic [31:0] hp;
      model_reset();
      do_reset(3);

      // Oscillator at half_period 4, then a change to 6 mid half-cycle.
      for (int i = 0; i < 18; i++) step(1'b1, 32'd4, 1'b1);
      for (int i = 0; i < 30; i++) step(1'b1, 32'd6, 1'b1);

      // Attack up to saturation, one tick every 10 clocks.
      for (int t = 0; t < 1100; t++) begin
         hp = 32'($urandom_range(1, 12));
         for (int k = 0; k < 9; k++) step(1'b1, hp, 1'b0);
         step(1'b1, hp, 1'b1);
      end
      @(posedge clock);
      #2;
      check("sustain_reached", longint'(env_state), 2);

      // Release down to near 1000000, then retrigger from there.
      for (int t = 0; t < 1560; t++) begin
         step(1'b0, 32'd5, 1'b0);
         step(1'b0, 32'd5, 1'b1);
      end
      step(1'b1, 32'd5, 1'b1);
      @(posedge clock);
      #2;
      check("retrigger_attack", longint'(env_state), 1);
      for (int t = 0; t < 40; t++) step(1'b1, 32'd5, 1'b1);

      // Release all the way to idle with back-to-back ticks.
      for (int t = 0; t < 2200; t++) step(1'b0, 32'd3, 1'b1);
      @(posedge clock);
      #2;
      check("release_idle", longint'(env_state), 0);

      // Silence: no note period while the key is held.
      for (int t = 0; t < 300; t++) step(1'b1, 32'd0, 1'($urandom_range(0, 1)));

      // Randomized mix of keys, periods and tick spacing.
      for (int t = 0; t < 3000; t++) begin
         hp = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
         step(($urandom_range(0, 99) < 70), hp, ($urandom_range(0, 2) == 0));
      end

      // Reset in the middle of a held note.
      for (int t = 0; t < 200; t++) step(1'b1, 32'd7, 1'b1);
      do_reset(4);
      for (int t = 0; t < 800; t++) begin
         hp = 32'($urandom_range(1, 15));
         step(($urandom_range(0, 99) < 80), hp, ($urandom_range(0, 1) == 1));
      end

      step(1'b0, 32'd5, 1'b0);
      @(negedge clock);
      @(negedge clock);
      check("scoreboard_drained", longint'(sb_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
